// File: rtl/i2s_tx_arbiter.sv
// i2s_tx_arbiter: round-robin scheduler feeding one stereo sample per I2S frame to a shared i2s_tx.
// Ports: clk/rst (sync, active-high); wclk from i2s_tx (falling edge = frame start);
// src_en/src_valid/src_left/src_right/src_ready per-source valid/ready inputs (source i at [i*WIDTH +: WIDTH]);
// out_left/out_right/grant_id/grant_valid sample presented to i2s_tx; underrun pulse and saturating underrun_count.
module i2s_tx_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int WIDTH = 16,
  parameter int UNDERRUN_ZERO = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wclk,
  input  logic [NUM_SRC-1:0]                 src_en,
  input  logic [NUM_SRC-1:0]                 src_valid,
  input  logic [NUM_SRC*WIDTH-1:0]           src_left,
  input  logic [NUM_SRC*WIDTH-1:0]           src_right,
  output logic [NUM_SRC-1:0]                 src_ready,
  output logic [WIDTH-1:0]                   out_left,
  output logic [WIDTH-1:0]                   out_right,
  output logic [$clog2(NUM_SRC)-1:0]         grant_id,
  output logic                               grant_valid,
  output logic                               underrun,
  output logic [15:0]                        underrun_count
);
  localparam int IW = $clog2(NUM_SRC);
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HELD = 1'b1;
  logic [0:0] state;
  logic [IW-1:0] ptr, win, stg_id;
  logic found, wclk_q, frame_edge, grant;
  logic [NUM_SRC-1:0] cand;
  logic [WIDTH-1:0] stg_l, stg_r, win_l, win_r;
  assign frame_edge = wclk_q & ~wclk;
  assign cand = src_en & src_valid;
  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (cand[(int'(ptr) + k) % NUM_SRC]) begin
        win = IW'((int'(ptr) + k) % NUM_SRC);
        found = 1'b1;
      end
  end
  assign win_l = src_left[win*WIDTH +: WIDTH];
  assign win_r = src_right[win*WIDTH +: WIDTH];
  assign grant = (state == FILL) & found & ~rst;
  assign src_ready = grant ? NUM_SRC'(1) << win : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      ptr <= '0;
      stg_id <= '0;
      stg_l <= '0;
      stg_r <= '0;
      wclk_q <= 1'b0;
      out_left <= '0;
      out_right <= '0;
      grant_id <= '0;
      grant_valid <= 1'b0;
      underrun <= 1'b0;
      underrun_count <= '0;
    end else begin
      wclk_q <= wclk;
      underrun <= 1'b0;
      if (state == HELD) begin
        if (frame_edge) begin
          out_left <= stg_l;
          out_right <= stg_r;
          grant_id <= stg_id;
          grant_valid <= 1'b1;
          state <= FILL;
        end
      end else if (found) begin
        ptr <= IW'((int'(win) + 1) % NUM_SRC);
        // A sample accepted on the frame edge itself goes straight out; otherwise it waits in staging.
        if (frame_edge) begin
          out_left <= win_l;
          out_right <= win_r;
          grant_id <= win;
          grant_valid <= 1'b1;
        end else begin
          stg_l <= win_l;
          stg_r <= win_r;
          stg_id <= win;
          state <= HELD;
        end
      end else if (frame_edge) begin
        underrun <= 1'b1;
        if (~&underrun_count) underrun_count <= underrun_count + 16'd1;
        grant_valid <= 1'b0;
        if (UNDERRUN_ZERO != 0) begin
          out_left <= '0;
          out_right <= '0;
        end
      end
    end
  end
endmodule
